// File: rtl/iic_slave_core_if.sv
// iic_slave_core_if: FIFO-side handshake of the IIC responder.
// The core is the master of this interface: it issues the push/pop strobes.
// The FIFOs sit on the slave side.
interface iic_slave_core_if;
  logic       rx_wr_en;
  logic [7:0] rx_wr_data;
  logic       rx_wr_ready;
  logic       tx_rd_en;
  logic [7:0] tx_rd_data;
  logic       tx_empty;

  modport master (output rx_wr_en, rx_wr_data, tx_rd_en,
                  input  rx_wr_ready, tx_rd_data, tx_empty);
  modport slave  (input  rx_wr_en, rx_wr_data, tx_rd_en,
                  output rx_wr_ready, tx_rd_data, tx_empty);
endinterface

// File: rtl/iic_slave_core.sv
// iic_slave_core: IIC responder byte engine.
// It filters SCL/SDA and detects START, repeated START and STOP.
// It matches a fixed 7-bit address.
// Write bytes are pushed to an RX FIFO; read bytes are popped from an FWFT TX FIFO.
// There is no clock stretching. SDA is open-drain via sda_oe.

// One bus line: 2-FF synchronizer followed by a run-length glitch filter.
// lvl_nxt_o exposes the filter's next level so edge flags can be registered
// in the same cycle the filtered level flips.
module iic_slave_filt #(
  parameter int FILT_LEN = 3
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic raw_i,
  output logic lvl_o,
  output logic lvl_nxt_o
);
  logic [1:0] sync_q, sync_d;
  logic [3:0] run_q, run_d;
  logic       lvl_q, lvl_d;

  // Flip the level only after FILT_LEN consecutive disagreeing samples.
  always_comb begin
    sync_d = {sync_q[0], raw_i};
    run_d  = '0;
    lvl_d  = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (run_q == 4'(FILT_LEN - 1)) lvl_d = sync_q[1];
      else                           run_d = run_q + 4'd1;
    end
  end

  // Synchronizer and filter state; both preset to an idle-high bus.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      sync_q <= 2'b11;
      run_q  <= '0;
      lvl_q  <= 1'b1;
    end else begin
      sync_q <= sync_d;
      run_q  <= run_d;
      lvl_q  <= lvl_d;
    end
  end

  assign lvl_o     = lvl_q;
  assign lvl_nxt_o = lvl_d;
endmodule

module iic_slave_core #(
  parameter logic [6:0] SLV_ADDR = 7'h50,
  parameter int         FILT_LEN = 3,
  parameter int         U_DLY    = 1
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe,
  iic_slave_core_if.master  fifo,
  output logic              busy,
  output logic              addr_hit,
  output logic              stop_det,
  output logic              rx_ovf,
  output logic              tx_unf
);
  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, RX_BYTE, RX_ACK, TX_BYTE, TX_ACK, WAIT_STOP
  } state_t;

  // The register delay parameter only matters to behavioural models.
  // This synthesizable body does not use it.
  logic unused_dly;
  assign unused_dly = (U_DLY != 0);

  // Line index 0 = SCL, 1 = SDA.
  logic [1:0] lvl, lvl_nxt;
  iic_slave_filt #(.FILT_LEN(FILT_LEN)) u_filt [1:0] (
    .clk_sys   (clk_sys),
    .rst       (rst),
    .raw_i     ({sda_i, scl_i}),
    .lvl_o     (lvl),
    .lvl_nxt_o (lvl_nxt)
  );

  logic scl_rise_q, scl_rise_d, scl_fall_q, scl_fall_d;
  logic start_q, start_d, stop_q, stop_d;

  // Edge and bus-condition flags, taken from the filtered level transitions.
  always_comb begin
    scl_rise_d = ~lvl[0] &  lvl_nxt[0];
    scl_fall_d =  lvl[0] & ~lvl_nxt[0];
    start_d    =  lvl[0] &  lvl_nxt[0] &  lvl[1] & ~lvl_nxt[1];
    stop_d     =  lvl[0] &  lvl_nxt[0] & ~lvl[1] &  lvl_nxt[1];
  end

  // Flag registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      scl_rise_q <= 1'b0;
      scl_fall_q <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
    end else begin
      scl_rise_q <= scl_rise_d;
      scl_fall_q <= scl_fall_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
    end
  end

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d, rx_wr_data_q, rx_wr_data_d, byte_in, tx_byte;
  logic       rw_q, rw_d, ack_q, ack_d, ph_q, ph_d, load;
  logic       sda_oe_q, sda_oe_d, busy_q, busy_d;
  logic       rx_wr_en_q, rx_wr_en_d, tx_rd_en_q, tx_rd_en_d;
  logic       addr_hit_q, addr_hit_d, stop_det_q, stop_det_d;
  logic       rx_ovf_q, rx_ovf_d, tx_unf_q, tx_unf_d;

  // Next state and outputs. START/STOP outrank every per-state action.
  // ph_q marks the second SCL fall of an ACK slot.
  // ack_q holds the RX ACK decision, or that the master ACKed in TX_ACK.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sh_d         = sh_q;
    rw_d         = rw_q;
    ack_d        = ack_q;
    ph_d         = ph_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    rx_wr_data_d = rx_wr_data_q;
    rx_wr_en_d   = 1'b0;
    tx_rd_en_d   = 1'b0;
    addr_hit_d   = 1'b0;
    stop_det_d   = 1'b0;
    rx_ovf_d     = 1'b0;
    tx_unf_d     = 1'b0;
    load         = 1'b0;
    byte_in      = {sh_q[6:0], lvl[1]};
    tx_byte      = fifo.tx_empty ? 8'hFF : fifo.tx_rd_data;
    if (start_q) begin
      state_d  = ADDR;
      cnt_d    = '0;
      sda_oe_d = 1'b0;
      busy_d   = 1'b1;
    end else if (stop_q) begin
      state_d    = IDLE;
      cnt_d      = '0;
      sda_oe_d   = 1'b0;
      busy_d     = 1'b0;
      stop_det_d = 1'b1;
    end else begin
      case (state_q)
        ADDR: if (scl_rise_q) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            if (byte_in[7:1] == SLV_ADDR) begin
              state_d = ADDR_ACK;
              rw_d    = byte_in[0];
              ph_d    = 1'b0;
            end else begin
              state_d = WAIT_STOP;
            end
          end
        end
        ADDR_ACK: if (scl_fall_q) begin
          if (!ph_q) begin
            sda_oe_d   = 1'b1;
            addr_hit_d = 1'b1;
            ph_d       = 1'b1;
          end else if (!rw_q) begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = RX_BYTE;
          end else begin
            load = 1'b1;
          end
        end
        RX_BYTE: if (scl_rise_q) begin
          sh_d  = byte_in;
          cnt_d = cnt_q + 3'd1;
          if (cnt_q == 3'd7) begin
            state_d = RX_ACK;
            ph_d    = 1'b0;
            ack_d   = fifo.rx_wr_ready;
            if (fifo.rx_wr_ready) begin
              rx_wr_en_d   = 1'b1;
              rx_wr_data_d = byte_in;
            end else begin
              rx_ovf_d = 1'b1;
            end
          end
        end
        RX_ACK: if (scl_fall_q) begin
          if (!ph_q) begin
            sda_oe_d = ack_q;
            ph_d     = 1'b1;
          end else begin
            sda_oe_d = 1'b0;
            cnt_d    = '0;
            state_d  = RX_BYTE;
          end
        end
        TX_BYTE: if (scl_fall_q) begin
          if (cnt_q == 3'd7) begin
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            state_d  = TX_ACK;
          end else begin
            sh_d     = {sh_q[6:0], 1'b0};
            sda_oe_d = ~sh_q[6];
            cnt_d    = cnt_q + 3'd1;
          end
        end
        TX_ACK: begin
          if (scl_rise_q) begin
            if (lvl[1]) begin
              state_d  = WAIT_STOP;
              sda_oe_d = 1'b0;
            end else begin
              ack_d = 1'b1;
            end
          end else if (scl_fall_q && ack_q) begin
            load = 1'b1;
          end
        end
        WAIT_STOP: sda_oe_d = 1'b0;
        default: ;
      endcase
      // Byte load on entry to TX_BYTE; an empty FIFO sends all ones.
      if (load) begin
        state_d    = TX_BYTE;
        cnt_d      = '0;
        sh_d       = tx_byte;
        sda_oe_d   = ~tx_byte[7];
        tx_rd_en_d = ~fifo.tx_empty;
        tx_unf_d   = fifo.tx_empty;
      end
    end
  end

  // FSM and output registers.
  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      sh_q         <= '0;
      rw_q         <= 1'b0;
      ack_q        <= 1'b0;
      ph_q         <= 1'b0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      rx_wr_data_q <= '0;
      rx_wr_en_q   <= 1'b0;
      tx_rd_en_q   <= 1'b0;
      addr_hit_q   <= 1'b0;
      stop_det_q   <= 1'b0;
      rx_ovf_q     <= 1'b0;
      tx_unf_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      sh_q         <= sh_d;
      rw_q         <= rw_d;
      ack_q        <= ack_d;
      ph_q         <= ph_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      rx_wr_data_q <= rx_wr_data_d;
      rx_wr_en_q   <= rx_wr_en_d;
      tx_rd_en_q   <= tx_rd_en_d;
      addr_hit_q   <= addr_hit_d;
      stop_det_q   <= stop_det_d;
      rx_ovf_q     <= rx_ovf_d;
      tx_unf_q     <= tx_unf_d;
    end
  end

  assign sda_oe          = sda_oe_q;
  assign busy            = busy_q;
  assign addr_hit        = addr_hit_q;
  assign stop_det        = stop_det_q;
  assign rx_ovf          = rx_ovf_q;
  assign tx_unf          = tx_unf_q;
  assign fifo.rx_wr_en   = rx_wr_en_q;
  assign fifo.rx_wr_data = rx_wr_data_q;
  assign fifo.tx_rd_en   = tx_rd_en_q;
endmodule

// File: tb/tb_iic_slave_core.sv
// tb_iic_slave_core: directed IIC master transactions against the responder.
// It uses an open-drain bus model and FIFO models.
// SCL is scaled to 100 clk_sys cycles per bit.
module tb_iic_slave_core;
  localparam int Q = 25;  // quarter SCL period in clk_sys cycles

  logic clk_sys = 1'b0;
  logic rst     = 1'b1;
  logic m_scl   = 1'b1;
  logic m_sda   = 1'b1;
  logic rdy     = 1'b1;
  logic sda_bus;
  logic sda_oe, busy, addr_hit, stop_det, rx_ovf, tx_unf;

  iic_slave_core_if ff();

  assign sda_bus        = m_sda & ~sda_oe;
  assign ff.rx_wr_ready = rdy;

  always #5 clk_sys = ~clk_sys;

  iic_slave_core #(.SLV_ADDR(7'h50), .FILT_LEN(3), .U_DLY(1)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .scl_i    (m_scl),
    .sda_i    (sda_bus),
    .sda_oe   (sda_oe),
    .fifo     (ff),
    .busy     (busy),
    .addr_hit (addr_hit),
    .stop_det (stop_det),
    .rx_ovf   (rx_ovf),
    .tx_unf   (tx_unf)
  );

  // Free-running event counters and FIFO models; tests look at deltas.
  int         n_hit, n_stop, n_ovf, n_unf, n_rd, n_oe;
  logic [7:0] rx_log[$];
  logic [7:0] txq[$];

  always @(negedge clk_sys) begin
    if (addr_hit)  n_hit  <= n_hit + 1;
    if (stop_det)  n_stop <= n_stop + 1;
    if (rx_ovf)    n_ovf  <= n_ovf + 1;
    if (tx_unf)    n_unf  <= n_unf + 1;
    if (sda_oe)    n_oe   <= n_oe + 1;
    if (ff.tx_rd_en) begin
      n_rd <= n_rd + 1;
      if (txq.size() > 0) void'(txq.pop_front());
    end
    if (ff.rx_wr_en) rx_log.push_back(ff.rx_wr_data);
    ff.tx_empty   <= (txq.size() == 0);
    ff.tx_rd_data <= (txq.size() > 0) ? txq[0] : 8'h00;
  end

  int n_chk, n_err;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wq(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  task automatic m_start;
    m_sda = 1'b1; wq(Q);
    m_scl = 1'b1; wq(2*Q);
    m_sda = 1'b0; wq(2*Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic m_stop;
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(2*Q);
    m_sda = 1'b1; wq(2*Q);
  endtask

  task automatic m_bit(input logic b, output logic rd, output logic oe);
    m_sda = b;    wq(Q);
    m_scl = 1'b1; wq(Q);
    rd = sda_bus;
    oe = sda_oe;  wq(Q);
    m_scl = 1'b0; wq(Q);
  endtask

  task automatic m_wr(input logic [7:0] d, output logic ack, output logic oe9);
    logic rd, oe;
    for (int i = 7; i >= 0; i--) m_bit(d[i], rd, oe);
    m_bit(1'b1, rd, oe);
    ack = ~rd;
    oe9 = oe;
  endtask

  task automatic m_rd(input logic mack, output logic [7:0] d);
    logic rd, oe;
    for (int i = 7; i >= 0; i--) begin
      m_bit(1'b1, rd, oe);
      d[i] = rd;
    end
    m_bit(~mack, rd, oe);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not reach the summary");
    $fatal(1);
  end

  initial begin
    logic       ack, oe9;
    logic [7:0] d;
    int b_hit, b_stop, b_ovf, b_unf, b_rd, b_oe, b_rx;

    wq(5);
    chk("rst_sda_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rx_wr_en", ff.rx_wr_en, 0);
    chk("rst_tx_rd_en", ff.tx_rd_en, 0);
    rst = 1'b0;
    wq(10);

    // 1: write 0x3C, 0x5A
    b_hit = n_hit; b_stop = n_stop; b_rx = rx_log.size();
    m_start;
    m_wr(8'hA0, ack, oe9); chk("t1_ack_addr", ack, 1); chk("t1_oe_addr", oe9, 1);
    chk("t1_busy", busy, 1);
    m_wr(8'h3C, ack, oe9); chk("t1_oe_b1", oe9, 1);
    m_wr(8'h5A, ack, oe9); chk("t1_oe_b2", oe9, 1);
    m_stop; wq(20);
    chk("t1_rx_n", rx_log.size() - b_rx, 2);
    if (rx_log.size() - b_rx == 2) begin
      chk("t1_rx0", rx_log[b_rx], 8'h3C);
      chk("t1_rx1", rx_log[b_rx+1], 8'h5A);
    end
    chk("t1_hit", n_hit - b_hit, 1);
    chk("t1_stop", n_stop - b_stop, 1);
    chk("t1_busy_end", busy, 0);

    // 2: read 0x11 (ACK), 0x22 (NACK)
    txq.push_back(8'h11); txq.push_back(8'h22); wq(5);
    b_rd = n_rd;
    m_start;
    m_wr(8'hA1, ack, oe9); chk("t2_ack_addr", ack, 1);
    m_rd(1'b1, d); chk("t2_d0", d, 8'h11);
    m_rd(1'b0, d); chk("t2_d1", d, 8'h22);
    m_stop; wq(20);
    chk("t2_rd", n_rd - b_rd, 2);
    chk("t2_idle", 32'(dut.state_q), 0);  // IDLE is the first enum value
    chk("t2_busy", busy, 0);

    // 3: address mismatch
    b_hit = n_hit; b_oe = n_oe; b_rx = rx_log.size(); b_rd = n_rd;
    m_start;
    m_wr(8'hA2, ack, oe9); chk("t3_nack_addr", ack, 0);
    m_wr(8'h55, ack, oe9); chk("t3_nack_b", ack, 0);
    chk("t3_busy", busy, 1);
    m_stop; wq(20);
    chk("t3_oe", n_oe - b_oe, 0);
    chk("t3_hit", n_hit - b_hit, 0);
    chk("t3_rx", rx_log.size() - b_rx, 0);
    chk("t3_rd", n_rd - b_rd, 0);
    chk("t3_busy_end", busy, 0);

    // 4: RX overflow on second data byte
    b_ovf = n_ovf; b_rx = rx_log.size();
    m_start;
    m_wr(8'hA0, ack, oe9);
    m_wr(8'h01, ack, oe9); chk("t4_ack1", ack, 1);
    rdy = 1'b0;
    m_wr(8'h02, ack, oe9); chk("t4_oe2", oe9, 0);
    rdy = 1'b1;
    m_stop; wq(20);
    chk("t4_rx_n", rx_log.size() - b_rx, 1);
    if (rx_log.size() - b_rx == 1) chk("t4_rx0", rx_log[b_rx], 8'h01);
    chk("t4_ovf", n_ovf - b_ovf, 1);

    // 5: read from empty TX FIFO
    b_unf = n_unf; b_rd = n_rd;
    m_start;
    m_wr(8'hA1, ack, oe9); chk("t5_ack_addr", ack, 1);
    b_oe = n_oe;
    m_rd(1'b0, d); chk("t5_d", d, 8'hFF);
    chk("t5_oe", n_oe - b_oe, 0);
    m_stop; wq(20);
    chk("t5_unf", n_unf - b_unf, 1);
    chk("t5_rd", n_rd - b_rd, 0);

    // 6: write then repeated START into a read
    txq.push_back(8'h77); wq(5);
    b_stop = n_stop; b_rd = n_rd; b_rx = rx_log.size();
    m_start;
    m_wr(8'hA0, ack, oe9);
    m_wr(8'h05, ack, oe9); chk("t6_ack_w", ack, 1);
    m_start;
    m_wr(8'hA1, ack, oe9); chk("t6_ack_rs", ack, 1);
    m_rd(1'b0, d); chk("t6_d", d, 8'h77);
    chk("t6_no_stop", n_stop - b_stop, 0);
    m_stop; wq(20);
    chk("t6_rd", n_rd - b_rd, 1);
    chk("t6_rx_n", rx_log.size() - b_rx, 1);
    if (rx_log.size() - b_rx == 1) chk("t6_rx0", rx_log[b_rx], 8'h05);

    // Reset mid-byte while the responder is pulling SDA low
    txq.push_back(8'h00); wq(5);
    m_start;
    m_wr(8'hA1, ack, oe9);
    wq(10);
    chk("rs_oe_pre", sda_oe, 1);
    rst = 1'b1; wq(1);
    chk("rs_oe", sda_oe, 0);
    chk("rs_idle", 32'(dut.state_q), 0);
    chk("rs_busy", busy, 0);
    rst = 1'b0;
    m_stop; wq(20);
    b_rx = rx_log.size();
    m_start;
    m_wr(8'hA0, ack, oe9); chk("rs_ack_addr", ack, 1);
    m_wr(8'h9C, ack, oe9); chk("rs_ack_b", ack, 1);
    m_stop; wq(20);
    chk("rs_rx_n", rx_log.size() - b_rx, 1);
    if (rx_log.size() - b_rx == 1) chk("rs_rx0", rx_log[b_rx], 8'h9C);

    // 2-cycle SDA glitch with SCL high: idle bus (would be START)
    wq(10);
    m_sda = 1'b0; wq(2); m_sda = 1'b1; wq(20);
    chk("gl_idle_busy", busy, 0);

    // 2-cycle SDA glitch with SCL high mid-byte (would be STOP)
    b_stop = n_stop; b_rx = rx_log.size();
    m_start;
    m_wr(8'hA0, ack, oe9);
    m_sda = 1'b0; wq(Q);
    m_scl = 1'b1; wq(Q/2);
    m_sda = 1'b1; wq(2); m_sda = 1'b0; wq(Q);
    m_scl = 1'b0; wq(Q);
    for (int i = 0; i < 7; i++) m_bit(1'b0, ack, oe9);
    m_bit(1'b1, ack, oe9); chk("gl_oe_ack", oe9, 1);
    chk("gl_busy", busy, 1);
    chk("gl_no_stop", n_stop - b_stop, 0);
    m_stop; wq(20);
    chk("gl_rx_n", rx_log.size() - b_rx, 1);
    if (rx_log.size() - b_rx == 1) chk("gl_rx0", rx_log[b_rx], 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
